// File: rtl/fetch_queue.sv
// Instruction FIFO between fetch and decode: one entry per fetched instruction
// (PC, word, BTB prediction), flushed wholesale on control redirects.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_predicted_pc,
  input  logic             enq_prediction_valid,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_inst,
  output logic [31:0]      deq_predicted_pc,
  output logic             deq_prediction_valid,
  output logic [PTR_W:0]   count
);

  localparam int ENTRY_W = 97;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               enq_fire, deq_fire;
  logic [ENTRY_W-1:0] head;

  // Full/empty come only from the registered count, never from pointer equality.
  assign enq_ready = (count_q != FULL_CNT);
  assign deq_valid = (count_q != '0);
  assign count     = count_q;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; an empty queue masks whatever it holds.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_q[wr_ptr_q] <= {enq_pc, enq_inst, enq_predicted_pc, enq_prediction_valid};
    end
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    if (!deq_valid) head = '0;
  end

  assign deq_pc               = head[96:65];
  assign deq_inst             = head[64:33];
  assign deq_predicted_pc     = head[32:1];
  assign deq_prediction_valid = head[0];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios then randomized traffic
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ppc;
    logic        pv;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic [31:0]      enq_pc = '0;
  logic [31:0]      enq_inst = '0;
  logic [31:0]      enq_predicted_pc = '0;
  logic             enq_prediction_valid = 1'b0;
  logic             deq_valid;
  logic             deq_ready = 1'b0;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_inst;
  logic [31:0]      deq_predicted_pc;
  logic             deq_prediction_valid;
  logic [PTR_W:0]   count;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  ent_t sb[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_inst(enq_inst),
    .enq_predicted_pc(enq_predicted_pc), .enq_prediction_valid(enq_prediction_valid),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_inst(deq_inst),
    .deq_predicted_pc(deq_predicted_pc), .deq_prediction_valid(deq_prediction_valid),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares the visible state with the model, pops on a dequeue.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("count", 64'(count), 64'(sb.size()));
      chk("deq_valid", 64'(deq_valid), 64'(sb.size() != 0));
      chk("enq_ready", 64'(enq_ready), 64'(sb.size() != DEPTH));
      if (sb.size() != 0) begin
        chk("deq_pc", 64'(deq_pc), 64'(sb[0].pc));
        chk("deq_inst", 64'(deq_inst), 64'(sb[0].inst));
        chk("deq_ppc", 64'(deq_predicted_pc), 64'(sb[0].ppc));
        chk("deq_pv", 64'(deq_prediction_valid), 64'(sb[0].pv));
        if (deq_ready && !flush) begin
          $display("deq pc=%08h inst=%08h ppc=%08h pv=%0d", sb[0].pc, sb[0].inst, sb[0].ppc, sb[0].pv);
          void'(sb.pop_front());
        end
      end else begin
        chk("bubble_data", {deq_pc, deq_inst}, 64'd0);
        chk("bubble_pred", {31'd0, deq_prediction_valid, deq_predicted_pc}, 64'd0);
      end
    end
  end

  // Drives one cycle starting at posedge+1; model size here is the pre-edge occupancy.
  task automatic cycle(input bit fl, input bit ev, input ent_t e, input bit dr);
    bit will_enq;
    flush = fl;
    enq_valid = ev;
    enq_pc = e.pc;
    enq_inst = e.inst;
    enq_predicted_pc = e.ppc;
    enq_prediction_valid = e.pv;
    deq_ready = dr;
    will_enq = ev && (sb.size() < DEPTH) && !fl;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else if (will_enq) sb.push_back(e);
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc = pc;
    e.inst = pc ^ 32'h0000_0013;
    e.ppc = pc + 32'd8;
    e.pv = pc[2];
    return e;
  endfunction

  function automatic ent_t rnd();
    ent_t e;
    e.pc = $urandom;
    e.inst = $urandom;
    e.ppc = $urandom;
    e.pv = 1'($urandom_range(0, 1));
    return e;
  endfunction

  initial begin
    ent_t idle;
    idle = '0;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_deq_pc", 64'(deq_pc), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Fill; the fifth offer must be refused.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, mk(32'h8000_0000 + 32'(4 * i)), 1'b0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_head", 64'(deq_pc), 64'h8000_0000);
    // Drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, idle, 1'b1);
    cycle(1'b0, 1'b0, idle, 1'b0);

    // Stream across the pointer wrap at constant occupancy 2.
    cycle(1'b0, 1'b1, mk(32'h8000_0200), 1'b0);
    cycle(1'b0, 1'b1, mk(32'h8000_0204), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, mk(32'h8000_0208 + 32'(4 * i)), 1'b1);
    chk("stream_count", 64'(count), 64'd2);

    // Flush beats a same-cycle enqueue and dequeue.
    cycle(1'b0, 1'b1, mk(32'h8000_0300), 1'b0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cycle(1'b1, 1'b1, mk(32'h8000_0400), 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    cycle(1'b0, 1'b1, mk(32'h8000_0100), 1'b0);
    chk("post_flush_head", 64'(deq_pc), 64'h8000_0100);

    // Full plus dequeue: enqueue refused, then accepted next edge.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, mk(32'h8000_0500 + 32'(4 * i)), 1'b0);
    cycle(1'b0, 1'b1, mk(32'h8000_0600), 1'b1);
    chk("full_deq_count", 64'(count), 64'd3);
    cycle(1'b0, 1'b1, mk(32'h8000_0600), 1'b0);
    chk("refill_count", 64'(count), 64'd4);

    // Asynchronous reset between edges with two entries held.
    cycle(1'b0, 1'b0, idle, 1'b1);
    cycle(1'b0, 1'b0, idle, 1'b1);
    chk("pre_reset_count", 64'(count), 64'd2);
    deq_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_deq_valid", 64'(deq_valid), 64'd0);
    chk("async_pred", {31'd0, deq_prediction_valid, deq_predicted_pc}, 64'd0);
    sb.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 70, rnd(), $urandom_range(0, 99) < 55);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small synchronous instruction FIFO between the fetch stage and the decode stage.
- Decouples icache hit/miss timing from decode stalls.
- Each entry carries one fetched instruction with its PC and BTB prediction.
- Control redirects flush the whole queue.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard all entries and any enqueue this cycle (mispredict / ID redirect)
enq_valid  input  1  fetch stage offers an instruction (icache ready)
enq_ready  output  1  queue can accept an entry this cycle
enq_pc  input  32  PC of offered instruction
enq_inst  input  32  instruction word
enq_predicted_pc  input  32  BTB-predicted next PC
enq_prediction_valid  input  1  BTB predicted taken
deq_valid  output  1  head entry valid for decode
deq_ready  input  1  decode consumes head this cycle (not stalled)
deq_pc  output  32  head PC
deq_inst  output  32  head instruction
deq_predicted_pc  output  32  head predicted PC
deq_prediction_valid  output  1  head prediction flag
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - deq_valid = 0, enq_ready = 1, all deq_* data = 0.
  - Entry storage need not be cleared.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Enqueue fires when enq_valid && enq_ready && !flush.
  - Entry is written at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap of the PTR_W-bit pointer).
- Dequeue fires when deq_valid && deq_ready && !flush.
  - rd_ptr increments modulo DEPTH.
- enq_ready = (count != DEPTH). Combinational from registered count only.
  - Must not depend on deq_ready, so a full queue refuses enqueue even when a dequeue fires the same cycle.
- deq_valid = (count != 0).
  - deq_* reflect the entry at rd_ptr, combinationally read from registered storage.
  - When count == 0, all deq_* data outputs are forced to 0, so decode sees a clean bubble.
- Latency: an entry enqueued at edge N is visible on deq_* after edge N. No same-cycle bypass from enq to deq.
- Count update:
  - enqueue only: +1
  - dequeue only: -1
  - both: unchanged (legal whenever 0 < count < DEPTH)
  - neither: unchanged
- Flush has highest priority below reset. On the edge where flush = 1:
  - wr_ptr = rd_ptr = count = 0.
  - The same-cycle enqueue and dequeue are both suppressed. Decode must not treat the head as consumed.
  - deq_valid is 0 in the following cycle.
  - enq_ready stays driven by the pre-flush count during the flush cycle; the producer ignores it because its request is dropped anyway.
- Ordering: strict FIFO; no reordering, no duplication, no loss except by flush or reset.
- Protocol rules:
  - Enqueue while full is ignored; the producer holds its data until enq_ready.
  - deq_ready while empty has no effect.
- Occupancy is never < 0 or > DEPTH; count is the authoritative full/empty indicator, not pointer equality.

Test Plan:
- Reset then fill: release rst_n, deq_ready=0, enqueue pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C on 4 consecutive edges -> count=4, enq_ready=0, deq_pc=0x80000000, deq_valid=1; a 5th offer (pc 0x80000010) is not stored.
- Drain in order: from the full state, deq_ready=1 for 4 edges -> deq_pc sequence 0x80000000/04/08/0C; then count=0, deq_valid=0, deq_inst=0.
- Simultaneous enq/deq with wrap: hold count=2 while streaming 10 entries (enq and deq every edge) -> count stays 2, output order equals input order across pointer wrap, no gaps.
- Flush priority: count=3, assert flush with enq_valid=1 and deq_ready=1 on the same edge -> next cycle count=0, deq_valid=0, the offered entry is absent; the next enqueue (pc 0x80000100) appears at the head after one edge.
- Full plus deq: count=4, enq_valid=1, deq_ready=1 -> dequeue occurs, enqueue refused, count=3; the offered entry is accepted on the next edge.
- Async reset mid-stream: drop rst_n between edges with count=2 -> deq_valid=0 and count=0 before the next rising clk; prediction fields read 0.
